// File: rtl/mtsp_bus_mq_if.sv
// Bus bundle between the MTSP thread pipeline, the command queue and the external memory bus.
// The slave modport is the queue's view; master is the pipeline/bus side.
interface mtsp_bus_mq_if #(
    parameter int TRD_COUNT  = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 128
);
    logic [TRD_COUNT-1:0]  nTRD;
    logic                  MEM_nEN;
    logic                  MEM_WRITE;
    logic [1:0]            MEM_OPT;
    logic [ADDR_W-1:0]     MEM_ADDR;
    logic [DATA_W-1:0]     MEM_DATA;
    logic                  MEM_STALL;
    logic                  PC_nWAIT;
    logic [TRD_COUNT-1:0]  PC_nAWAKE;
    logic                  CMD_EN;
    logic                  CMD_VALID;
    logic                  CMD_WRITE;
    logic [ADDR_W-1:0]     CMD_ADDR;
    logic [DATA_W-1:0]     CMD_DATA;
    logic [DEPTH_LOG2:0]   CMD_LEVEL;

    modport slave (
        input  nTRD, MEM_nEN, MEM_WRITE, MEM_OPT, MEM_ADDR, MEM_DATA, CMD_VALID,
        output MEM_STALL, PC_nWAIT, PC_nAWAKE, CMD_EN, CMD_WRITE, CMD_ADDR, CMD_DATA, CMD_LEVEL
    );

    modport master (
        output nTRD, MEM_nEN, MEM_WRITE, MEM_OPT, MEM_ADDR, MEM_DATA, CMD_VALID,
        input  MEM_STALL, PC_nWAIT, PC_nAWAKE, CMD_EN, CMD_WRITE, CMD_ADDR, CMD_DATA, CMD_LEVEL
    );
endinterface

// File: rtl/mtsp_bus_mq.sv
// Multi-thread bus command queue: FIFO of normal/bypass/prefetch commands, thread wake on drain,
// and per-thread outstanding-prefetch counters that gate wait commands and stall on saturation.
module mtsp_bus_mq #(
    parameter int TRD_COUNT  = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 128,
    parameter int PF_CNT_W   = 3
) (
    input  logic                CLK,
    input  logic                RST,
    mtsp_bus_mq_if.slave        bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PF_CNT_W-1:0] CNT_MAX = {PF_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        OPT_NORMAL   = 2'b00,
        OPT_BYPASS   = 2'b01,
        OPT_PREFETCH = 2'b10,
        OPT_WAIT     = 2'b11
    } opt_e;

    logic                  pfMem    [DEPTH];
    logic [TRD_COUNT-1:0]  maskMem  [DEPTH];
    logic                  writeMem [DEPTH];
    logic [ADDR_W-1:0]     addrMem  [DEPTH];
    logic [DATA_W-1:0]     dataMem  [DEPTH];

    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [TRD_COUNT-1:0]  awake_q, awake_d;
    logic [PF_CNT_W-1:0]   cnt_q [TRD_COUNT];
    logic [PF_CNT_W-1:0]   cnt_d [TRD_COUNT];

    opt_e                  opt;
    logic                  act, full, notEmpty, sat, pend;
    logic                  stall, push, pop, decAtZero;
    logic                  headPf;
    logic [TRD_COUNT-1:0]  headMask;

    assign opt      = opt_e'(bus.MEM_OPT);
    assign act      = ~bus.MEM_nEN;
    assign full     = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign notEmpty = (level_q != '0);
    assign headPf   = pfMem[rdPtr_q];
    assign headMask = maskMem[rdPtr_q];

    // Saturation and pending are judged only over the threads issuing this cycle.
    always_comb begin
        sat  = 1'b0;
        pend = 1'b0;
        for (int t = 0; t < TRD_COUNT; t++) begin
            if (!bus.nTRD[t] && cnt_q[t] == CNT_MAX) sat  = 1'b1;
            if (!bus.nTRD[t] && cnt_q[t] != '0)      pend = 1'b1;
        end
    end

    // Full is taken from registered level, so a pop in the same cycle never frees a slot for a push.
    assign stall = act & (opt != OPT_WAIT) & (full | ((opt == OPT_PREFETCH) & sat));
    assign push  = act & (opt != OPT_WAIT) & ~stall;
    assign pop   = notEmpty & bus.CMD_VALID;

    always_comb begin
        wrPtr_d   = wrPtr_q + DEPTH_LOG2'(push);
        rdPtr_d   = rdPtr_q + DEPTH_LOG2'(pop);
        level_d   = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        awake_d   = (pop & ~headPf) ? headMask : '1;
        decAtZero = 1'b0;
        for (int t = 0; t < TRD_COUNT; t++) begin
            cnt_d[t] = cnt_q[t];
            case ({push & (opt == OPT_PREFETCH) & ~bus.nTRD[t], pop & headPf & ~headMask[t]})
                2'b10:   cnt_d[t] = cnt_q[t] + PF_CNT_W'(1);
                2'b01:   cnt_d[t] = cnt_q[t] - PF_CNT_W'(1);
                default: cnt_d[t] = cnt_q[t];
            endcase
            if (pop && headPf && !headMask[t] && cnt_q[t] == '0) decAtZero = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
            awake_q <= '1;
            for (int t = 0; t < TRD_COUNT; t++) cnt_q[t] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
            awake_q <= awake_d;
            for (int t = 0; t < TRD_COUNT; t++) cnt_q[t] <= cnt_d[t];
        end
    end

    // Storage is left unreset: entries become unreachable once the pointers clear.
    always_ff @(posedge CLK) begin
        if (push) begin
            pfMem[wrPtr_q]    <= (opt == OPT_PREFETCH);
            maskMem[wrPtr_q]  <= (opt == OPT_BYPASS) ? '1 : bus.nTRD;
            writeMem[wrPtr_q] <= bus.MEM_WRITE;
            addrMem[wrPtr_q]  <= bus.MEM_ADDR;
            dataMem[wrPtr_q]  <= bus.MEM_DATA;
        end
    end

    assign bus.MEM_STALL = stall;
    assign bus.PC_nWAIT  = ~(act & ~stall & ((opt == OPT_NORMAL) | ((opt == OPT_WAIT) & pend)));
    assign bus.PC_nAWAKE = awake_q;
    assign bus.CMD_EN    = notEmpty;
    assign bus.CMD_WRITE = writeMem[rdPtr_q];
    assign bus.CMD_ADDR  = addrMem[rdPtr_q];
    assign bus.CMD_DATA  = dataMem[rdPtr_q];
    assign bus.CMD_LEVEL = level_q;

    // Every prefetch pop was counted when pushed, so its counter can never already be zero.
    assert property (@(posedge CLK) disable iff (RST) !decAtZero);

endmodule

// File: tb/tb_mtsp_bus_mq.sv
// Randomized and directed bench for mtsp_bus_mq against a queue-based reference model.
module tb_mtsp_bus_mq;
    typedef struct {
        bit          pf;
        logic [7:0]  mask;
        bit          wr;
        logic [13:0] addr;
        logic [127:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    entry_t     modelQ[$];
    int         modelCnt[8];
    logic [7:0] modelAwake = 8'hFF;

    mtsp_bus_mq_if #(.TRD_COUNT(8), .DEPTH_LOG2(4), .ADDR_W(14), .DATA_W(128)) bus ();

    mtsp_bus_mq #(
        .TRD_COUNT(8), .DEPTH_LOG2(4), .ADDR_W(14), .DATA_W(128), .PF_CNT_W(3)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle: check registered outputs, drive inputs, check combinational outputs, advance model.
    task automatic applyStimulus(input logic rstV, input logic [7:0] nTrdV, input logic nEnV,
                                 input logic wrV, input logic [1:0] optV, input logic [13:0] addrV,
                                 input logic [127:0] dataV, input logic validV);
        bit act, full, sat, pend, expStall, expNWait, doPop, doPush;
        entry_t head, e;
        @(negedge clk);
        checkOutput("CMD_EN", bus.CMD_EN, modelQ.size() != 0);
        checkOutput("CMD_LEVEL", bus.CMD_LEVEL, modelQ.size());
        checkOutput("PC_nAWAKE", bus.PC_nAWAKE, modelAwake);
        if (modelQ.size() != 0) begin
            checkOutput("CMD_WRITE", bus.CMD_WRITE, modelQ[0].wr);
            checkOutput("CMD_ADDR", bus.CMD_ADDR, modelQ[0].addr);
            checkOutput("CMD_DATA", bus.CMD_DATA, modelQ[0].data);
        end
        rst           = rstV;
        bus.nTRD      = nTrdV;
        bus.MEM_nEN   = nEnV;
        bus.MEM_WRITE = wrV;
        bus.MEM_OPT   = optV;
        bus.MEM_ADDR  = addrV;
        bus.MEM_DATA  = dataV;
        bus.CMD_VALID = validV;
        #1;
        act  = !nEnV;
        full = (modelQ.size() == 16);
        sat  = 0;
        pend = 0;
        for (int t = 0; t < 8; t++) begin
            if (!nTrdV[t] && modelCnt[t] == 7) sat = 1;
            if (!nTrdV[t] && modelCnt[t] != 0) pend = 1;
        end
        expStall = act && optV != 2'b11 && (full || (optV == 2'b10 && sat));
        expNWait = !(act && !expStall && (optV == 2'b00 || (optV == 2'b11 && pend)));
        checkOutput("MEM_STALL", bus.MEM_STALL, expStall);
        checkOutput("PC_nWAIT", bus.PC_nWAIT, expNWait);
        if (rstV) begin
            modelQ.delete();
            for (int t = 0; t < 8; t++) modelCnt[t] = 0;
            modelAwake = 8'hFF;
        end else begin
            doPop  = (modelQ.size() != 0) && validV;
            doPush = act && optV != 2'b11 && !expStall;
            modelAwake = 8'hFF;
            if (doPop) begin
                head = modelQ.pop_front();
                if (!head.pf) modelAwake = head.mask;
                else for (int t = 0; t < 8; t++) if (!head.mask[t]) modelCnt[t]--;
            end
            if (doPush) begin
                e.pf   = (optV == 2'b10);
                e.mask = (optV == 2'b01) ? 8'hFF : nTrdV;
                e.wr   = wrV;
                e.addr = addrV;
                e.data = dataV;
                modelQ.push_back(e);
                if (e.pf) for (int t = 0; t < 8; t++) if (!nTrdV[t]) modelCnt[t]++;
            end
        end
    endtask

    task automatic issue(input logic [7:0] nTrdV, input logic [1:0] optV, input logic validV);
        applyStimulus(0, nTrdV, 0, $urandom_range(0, 1), optV, 14'($urandom),
                      {$urandom, $urandom, $urandom, $urandom}, validV);
    endtask

    task automatic idle(input logic validV);
        applyStimulus(0, 8'hFF, 1, 0, 2'b00, 14'h0, 128'h0, validV);
    endtask

    initial begin
        logic [7:0] nTrdR;
        int validPct, trdMax;
        bus.nTRD = 8'hFF; bus.MEM_nEN = 1; bus.MEM_WRITE = 0; bus.MEM_OPT = 0;
        bus.MEM_ADDR = 0; bus.MEM_DATA = 0; bus.CMD_VALID = 0;
        applyStimulus(1, 8'hFF, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'hFF, 1, 0, 0, 0, 0, 0);

        // Normal read from thread 2, then pop and watch the wake pulse.
        applyStimulus(0, 8'hFB, 0, 0, 2'b00, 14'h0040, 128'h1234, 0);
        idle(1);
        idle(0);
        idle(0);

        // Bypass write: thread keeps running, no wake on drain.
        applyStimulus(0, 8'hFB, 0, 1, 2'b01, 14'h0155, 128'hABCD, 0);
        idle(0);
        idle(1);
        idle(0);

        // Fill to 16, overflow attempt, then push+pop while full.
        for (int i = 0; i < 16; i++) issue(8'hFE, 2'b00, 0);
        issue(8'hFD, 2'b00, 0);
        issue(8'hFD, 2'b00, 1);
        for (int i = 0; i < 17; i++) idle(1);

        // Thread 0 prefetches then waits; thread 1 wait passes immediately.
        for (int i = 0; i < 3; i++) issue(8'hFE, 2'b10, 0);
        issue(8'hFE, 2'b11, 0);
        issue(8'hFD, 2'b11, 0);
        for (int i = 0; i < 4; i++) begin
            issue(8'hFE, 2'b11, 1);
        end
        issue(8'hFE, 2'b11, 0);

        // Saturate thread 0's counter, then pop+prefetch in the same cycle.
        for (int i = 0; i < 7; i++) issue(8'hFE, 2'b10, 0);
        issue(8'hFE, 2'b10, 0);
        issue(8'hFE, 2'b10, 1);
        issue(8'hFE, 2'b10, 0);
        issue(8'hFE, 2'b11, 0);

        // Reset with entries queued and counters nonzero.
        issue(8'hFD, 2'b00, 0);
        applyStimulus(1, 8'hFF, 1, 0, 0, 0, 0, 0);
        idle(0);
        issue(8'hFE, 2'b11, 0);

        // Random phases with varying drain rate and thread spread.
        for (int phase = 0; phase < 6; phase++) begin
            validPct = (phase % 3 == 0) ? 10 : (phase % 3 == 1) ? 50 : 90;
            trdMax   = (phase < 3) ? 1 : 7;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 3) == 0) nTrdR = 8'($urandom);
                else nTrdR = ~(8'h01 << $urandom_range(0, trdMax));
                applyStimulus($urandom_range(0, 299) == 0, nTrdR, $urandom_range(0, 3) == 0,
                              $urandom_range(0, 1), 2'($urandom_range(0, 3)), 14'($urandom),
                              {$urandom, $urandom, $urandom, $urandom},
                              $urandom_range(0, 99) < validPct);
            end
        end
        for (int i = 0; i < 20; i++) idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
